// File: rtl/spi_bridge_controller_if.sv
// Parallel bus side of the SPI bridge: address/data, strobes and read data.
interface spi_bridge_controller_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
) ();
   logic [ADDR_W-1:0] address_o;
   logic [DATA_W-1:0] data_o;
   logic [DATA_W-1:0] data_i;
   logic              wr_stb_o;
   logic              rd_stb_o;

   modport master (output address_o, data_o, wr_stb_o, rd_stb_o, input data_i);
   modport slave  (input address_o, data_o, wr_stb_o, rd_stb_o, output data_i);
endinterface

// File: rtl/spi_bridge_controller.sv
// SPI (mode 0) slave to parallel bus bridge with per-word CRC-8 and burst
// auto-increment. SPI pins are oversampled by clk_i through 2-flop synchronisers.
module spi_bridge_controller #(
   parameter int          ADDR_W   = 15,
   parameter int          DATA_W   = 16,
   parameter logic [7:0]  CRC_INIT = 8'h9C,
   parameter int          BURST_EN = 1,
   parameter int          RD_LAT   = 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   spi_clk_i,
   input  logic                   spi_cs_n_i,
   input  logic                   spi_mosi_i,
   output logic                   spi_miso_o,
   spi_bridge_controller_if.master bus,
   output logic                   crc_err_o,
   output logic [7:0]             err_cnt_o,
   output logic                   busy_o
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_WDAT = 2'd2;
   localparam logic [1:0] S_RDAT = 2'd3;

   localparam int           CW          = 6;
   localparam logic [CW-1:0] C_HDR_LAST  = CW'(ADDR_W);
   localparam logic [CW-1:0] C_DW        = CW'(DATA_W);
   localparam logic [CW-1:0] C_WORD_LAST = CW'(DATA_W + 7);

   // One MSB-first step of CRC-8, polynomial x^8+x^2+x+1.
   function automatic logic [7:0] f_crc_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[7] ^ b;
      return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   function automatic logic [7:0] f_crc_word(input logic [DATA_W-1:0] d);
      logic [7:0] c;
      c = CRC_INIT;
      for (int i = DATA_W - 1; i >= 0; i--) c = f_crc_step(c, d[i]);
      return c;
   endfunction

   logic [1:0] r_clk_sync, r_cs_sync, r_mosi_sync;
   logic       r_clk_d, r_cs_d;
   logic       w_sclk, w_cs, w_mosi;
   logic       w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

   logic [1:0]          r_state;
   logic [CW-1:0]       r_bcnt;      // header bits, write bits (rises) or read bits (falls)
   logic                r_rw;
   logic                r_done;      // single-word frame finished, ignore the rest
   logic [ADDR_W-1:0]   r_hdr_addr;
   logic [ADDR_W-1:0]   r_waddr;     // address of the write word being received
   logic [ADDR_W-1:0]   r_nxt;       // next address to prefetch in a read burst
   logic [DATA_W-1:0]   r_wsh;
   logic [7:0]          r_crc;
   logic [6:0]          r_rxcrc;
   logic [DATA_W-1:0]   r_rbuf;      // fetched read word waiting for its turn on MISO
   logic [7:0]          r_rbuf_crc;
   logic [DATA_W+7:0]   r_tx;
   logic                r_miso;
   logic [ADDR_W-1:0]   r_address;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_wr_stb;
   logic                r_crc_err;
   logic [7:0]          r_err_cnt;
   logic [RD_LAT:0]     r_rdp;       // [0] is rd_stb_o, [RD_LAT] marks data_i valid

   logic [ADDR_W-1:0]   w_addr_full;
   logic [7:0]          w_crc_next;
   logic [7:0]          w_rx_crc;

   assign w_sclk      = r_clk_sync[1];
   assign w_cs        = r_cs_sync[1];
   assign w_mosi      = r_mosi_sync[1];
   assign w_sclk_rise = w_sclk & ~r_clk_d;
   assign w_sclk_fall = ~w_sclk & r_clk_d;
   assign w_cs_rise   = w_cs & ~r_cs_d;
   assign w_cs_fall   = ~w_cs & r_cs_d;

   assign w_addr_full = (r_hdr_addr << 1) | ADDR_W'(w_mosi);
   assign w_crc_next  = f_crc_step(r_crc, w_mosi);
   assign w_rx_crc    = {r_rxcrc, w_mosi};

   assign spi_miso_o    = r_miso;
   assign bus.address_o = r_address;
   assign bus.data_o    = r_wdata;
   assign bus.wr_stb_o  = r_wr_stb;
   assign bus.rd_stb_o  = r_rdp[0];
   assign crc_err_o     = r_crc_err;
   assign err_cnt_o     = r_err_cnt;
   assign busy_o        = (r_state != S_IDLE);

   // Synchronise the SPI pins and keep the previous level for edge detection.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_clk_sync  <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
         r_clk_d     <= 1'b0;
         r_cs_d      <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], spi_clk_i};
         r_cs_sync   <= {r_cs_sync[0], spi_cs_n_i};
         r_mosi_sync <= {r_mosi_sync[0], spi_mosi_i};
         r_clk_d     <= w_sclk;
         r_cs_d      <= w_cs;
      end
   end

   // Frame FSM: header decode, write word receive/check, read word fetch/shift.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state    <= S_IDLE;
         r_bcnt     <= '0;
         r_rw       <= 1'b0;
         r_done     <= 1'b0;
         r_hdr_addr <= '0;
         r_waddr    <= '0;
         r_nxt      <= '0;
         r_wsh      <= '0;
         r_crc      <= CRC_INIT;
         r_rxcrc    <= '0;
         r_rbuf     <= '0;
         r_rbuf_crc <= '0;
         r_tx       <= '0;
         r_miso     <= 1'b0;
         r_address  <= '0;
         r_wdata    <= '0;
         r_wr_stb   <= 1'b0;
         r_crc_err  <= 1'b0;
         r_err_cnt  <= '0;
         r_rdp      <= '0;
      end else begin
         r_wr_stb  <= 1'b0;
         r_crc_err <= 1'b0;
         for (int k = RD_LAT; k > 0; k--) r_rdp[k] <= r_rdp[k-1];
         r_rdp[0] <= 1'b0;
         if (r_rdp[RD_LAT]) begin
            r_rbuf     <= bus.data_i;
            r_rbuf_crc <= f_crc_word(bus.data_i);
         end

         if (w_cs_rise) begin
            r_state <= S_IDLE;
            r_miso  <= 1'b0;
            r_done  <= 1'b0;
         end else if (w_cs_fall) begin
            // a fall always restarts the header count, whatever state we were in
            r_state    <= S_HDR;
            r_bcnt     <= '0;
            r_hdr_addr <= '0;
            r_miso     <= 1'b0;
            r_done     <= 1'b0;
         end else begin
            case (r_state)
               S_HDR: if (w_sclk_rise) begin
                  if (r_bcnt == C_HDR_LAST) begin
                     r_bcnt <= '0;
                     r_crc  <= CRC_INIT;
                     if (r_rw) begin
                        r_state <= S_WDAT;
                        r_waddr <= w_addr_full;
                     end else begin
                        r_state   <= S_RDAT;
                        r_address <= w_addr_full;
                        r_rdp[0]  <= 1'b1;
                        r_nxt     <= w_addr_full + 1'b1;
                     end
                  end else begin
                     if (r_bcnt == '0) r_rw <= w_mosi;
                     else              r_hdr_addr <= w_addr_full;
                     r_bcnt <= r_bcnt + 1'b1;
                  end
               end
               S_WDAT: if (w_sclk_rise && !r_done) begin
                  if (r_bcnt < C_DW) begin
                     r_wsh  <= (r_wsh << 1) | DATA_W'(w_mosi);
                     r_crc  <= w_crc_next;
                     r_bcnt <= r_bcnt + 1'b1;
                  end else begin
                     r_rxcrc <= w_rx_crc[6:0];
                     if (r_bcnt == C_WORD_LAST) begin
                        if (w_rx_crc == r_crc) begin
                           r_wr_stb  <= 1'b1;
                           r_address <= r_waddr;
                           r_wdata   <= r_wsh;
                        end else begin
                           r_crc_err <= 1'b1;
                           if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_waddr <= r_waddr + 1'b1;
                        r_crc   <= CRC_INIT;
                        r_bcnt  <= '0;
                        if (BURST_EN == 0) r_done <= 1'b1;
                     end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                     end
                  end
               end
               S_RDAT: if (w_sclk_fall) begin
                  if (r_done) begin
                     r_miso <= 1'b0;
                  end else begin
                     if (r_bcnt == '0) begin
                        // word boundary: load the fetched word and prefetch the next one
                        r_miso <= r_rbuf[DATA_W-1];
                        r_tx   <= {r_rbuf, r_rbuf_crc} << 1;
                        if (BURST_EN != 0) begin
                           r_rdp[0]  <= 1'b1;
                           r_address <= r_nxt;
                           r_nxt     <= r_nxt + 1'b1;
                        end
                     end else begin
                        r_miso <= r_tx[DATA_W+7];
                        r_tx   <= r_tx << 1;
                     end
                     if (r_bcnt == C_WORD_LAST) begin
                        r_bcnt <= '0;
                        if (BURST_EN == 0) r_done <= 1'b1;
                     end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: doc/spi_bridge_controller.md
SPI_BRIDGE_CONTROLLER -- requirements
Module: spi_bridge_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 15: bus address width, 1..30.
REQ-002 SHALL have parameter DATA_W, default 16: bus data width, multiple of 8, 8..32.
REQ-003 SHALL have parameter CRC_INIT, default 8'h9C: CRC-8 seed, polynomial x^8+x^2+x+1, MSB-first.
REQ-004 SHALL have parameter BURST_EN, default 1: 1 means auto-increment multi-word frames, 0 means one word per frame.
REQ-005 SHALL have parameter RD_LAT, default 1: clk_i cycles from rd_stb_o to valid data_i, 0..4.
REQ-006 clk_i  input  1  sole clock; all logic on rising edge.
REQ-007 reset_i  input  1  synchronous, active-low reset.
REQ-008 spi_clk_i  input  1  SPI SCLK, mode 0, asynchronous.
REQ-009 spi_cs_n_i  input  1  chip select, active-low, asynchronous.
REQ-010 spi_mosi_i  input  1  serial in, asynchronous.
REQ-011 spi_miso_o  output  1  serial out.
REQ-012 address_o  output  ADDR_W  bus address, held until next strobe.
REQ-013 data_o  output  DATA_W  write data, held until next wr_stb_o.
REQ-014 data_i  input  DATA_W  read data.
REQ-015 wr_stb_o  output  1  one-cycle write pulse.
REQ-016 rd_stb_o  output  1  one-cycle read pulse.
REQ-017 crc_err_o  output  1  one-cycle pulse on rejected write word.
REQ-018 err_cnt_o  output  8  saturating count of CRC rejections.
REQ-019 busy_o  output  1  high while a frame is active (state not IDLE).

Function
REQ-020 SHALL pass spi_clk_i, spi_cs_n_i, spi_mosi_i through 2-flop synchronisers; SCLK edges SHALL be detected from the synchronised copy; clk_i SHALL be at least 8x SCLK.
REQ-021 Frame format: bit 1 is rw (1=write, 0=read), then ADDR_W address bits, then per word DATA_W data bits followed by 8 CRC bits; all fields MSB-first; MOSI sampled on SCLK rise.
REQ-022 FSM states: IDLE, HDR, WDAT, RDAT; IDLE->HDR on synchronised CS fall; HDR->WDAT or RDAT after the last address bit; any state->IDLE on synchronised CS rise.
REQ-023 Write: CRC SHALL be computed over the word's DATA_W bits from CRC_INIT; on match, wr_stb_o SHALL assert exactly 1 clk_i after the last CRC bit's edge is detected, with address_o/data_o valid in that cycle.
REQ-024 Write CRC mismatch: no wr_stb_o; crc_err_o pulses in the same cycle wr_stb_o would have pulsed; err_cnt_o increments, saturating at 255.
REQ-025 Read: rd_stb_o SHALL assert 1 clk_i after the last address bit's edge is detected; data_i SHALL be captured RD_LAT cycles later; CRC SHALL be computed over the captured word.
REQ-026 MISO SHALL update on the synchronised SCLK fall: the data MSB first, then the 8 CRC bits; MISO SHALL be 0 in IDLE and HDR.
REQ-027 Host timing: the SCLK half-period SHALL exceed (RD_LAT+5) clk_i cycles.
REQ-028 Burst (BURST_EN=1): with CS held low, each further word SHALL use address+1, wrapping modulo 2^ADDR_W.
REQ-029 Burst read: the next address SHALL be prefetched (rd_stb_o) on the cycle the current word loads into the shift register.
REQ-030 Burst disabled (BURST_EN=0): bits after the first word+CRC SHALL be ignored; MISO SHALL be 0 after that word.
REQ-031 CS rise mid-word SHALL discard the partial word with no strobe and no crc_err_o; completed earlier words SHALL stand.
REQ-032 A CS fall during the same cycle as an IDLE return SHALL start a new frame with a fresh bit count.
REQ-033 wr_stb_o and rd_stb_o SHALL never assert in the same cycle.

Reset
REQ-034 While reset_i is low at a clk_i edge: state=IDLE; all outputs 0; err_cnt_o=0; synchronisers cleared.
REQ-035 After reset_i is released, a frame SHALL be accepted only after a fresh CS fall; a frame in progress across reset SHALL be dropped.

Verification (ADDR_W=15, DATA_W=16, RD_LAT=1)
REQ-036 Write 0x1234 <- 0xBEEF, correct CRC -> one wr_stb_o, address_o=0x1234, data_o=0xBEEF, crc_err_o stays 0.
REQ-037 Same write with the CRC LSB flipped -> no wr_stb_o, one crc_err_o, err_cnt_o=1.
REQ-038 Read 0x0010 with data_i=0xA5A5 -> one rd_stb_o, address_o=0x0010, MISO=0xA5A5 then CRC(0x9C,0xA5A5).
REQ-039 Burst write of 3 words from 0x7FFE -> wr_stb_o at 0x7FFE, 0x7FFF, 0x0000 (wrap).
REQ-040 CS rise after 10 write-data bits -> no strobe, busy_o returns to 0; the next frame completes normally.
REQ-041 reset_i low mid read frame -> all outputs 0 next cycle; no further strobes until a new CS fall.
